// File: rtl/ps2_clk_edge_filter.sv
// Multi-channel PS/2 clock front end: two-flop synchroniser, glitch filter with
// registered fall/rise pulses, filtered level and bus-idle flag per channel.
module ps2_clk_edge_filter #(
    parameter int NUM_CH      = 1,
    parameter int FILTER_LEN  = 2,
    parameter int IDLE_CYCLES = 5000
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [NUM_CH-1:0] Enable,
    input  logic [NUM_CH-1:0] ClkKB,
    output logic [NUM_CH-1:0] FallKB,
    output logic [NUM_CH-1:0] RiseKB,
    output logic [NUM_CH-1:0] LevelKB,
    output logic [NUM_CH-1:0] Idle
);

    // state        | meaning
    // ST_HIGH      | line confirmed high, idle count running
    // ST_FALL_TEST | low samples seen, counting toward a confirmed fall
    // ST_LOW       | line confirmed low
    // ST_RISE_TEST | high samples seen, counting toward a confirmed rise
    typedef enum logic [1:0] {
        ST_HIGH      = 2'd0,
        ST_FALL_TEST = 2'd1,
        ST_LOW       = 2'd2,
        ST_RISE_TEST = 2'd3
    } state_t;

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int IW = $clog2(IDLE_CYCLES + 1);
    localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN);
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES);

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic          sync1_q, sync2_q;
        state_t        state_q, state_d;
        logic [FW-1:0] fcnt_q, fcnt_d, fcnt_inc;
        logic [IW-1:0] icnt_q, icnt_d;
        logic          fall_q, fall_d, rise_q, rise_d;
        logic          level_q, level_d, idle_q, idle_d;
        logic          s;

        assign s        = sync2_q;
        assign fcnt_inc = fcnt_q + FW'(1);

        always_ff @(posedge Clk or negedge Reset) begin
            if (!Reset) begin
                sync1_q <= 1'b1;
                sync2_q <= 1'b1;
                state_q <= ST_HIGH;
                fcnt_q  <= '0;
                icnt_q  <= '0;
                fall_q  <= 1'b0;
                rise_q  <= 1'b0;
                level_q <= 1'b1;
                idle_q  <= 1'b0;
            end else if (!Enable[ch]) begin
                sync1_q <= 1'b1;
                sync2_q <= 1'b1;
                state_q <= ST_HIGH;
                fcnt_q  <= '0;
                icnt_q  <= '0;
                fall_q  <= 1'b0;
                rise_q  <= 1'b0;
                level_q <= 1'b1;
                idle_q  <= 1'b0;
            end else begin
                sync1_q <= ClkKB[ch];
                sync2_q <= sync1_q;
                state_q <= state_d;
                fcnt_q  <= fcnt_d;
                icnt_q  <= icnt_d;
                fall_q  <= fall_d;
                rise_q  <= rise_d;
                level_q <= level_d;
                idle_q  <= idle_d;
            end
        end

        // Idle count only survives while sitting in ST_HIGH on a high sample.
        always_comb begin
            state_d = state_q;
            fcnt_d  = fcnt_q;
            icnt_d  = '0;
            fall_d  = 1'b0;
            rise_d  = 1'b0;
            level_d = level_q;
            idle_d  = 1'b0;
            case (state_q)
                ST_HIGH: begin
                    if (s) begin
                        icnt_d = (icnt_q == IDLE_MAX) ? icnt_q : icnt_q + IW'(1);
                        idle_d = (icnt_d == IDLE_MAX);
                    end else if (FILTER_LEN == 1) begin
                        state_d = ST_LOW;
                        fall_d  = 1'b1;
                        level_d = 1'b0;
                        fcnt_d  = '0;
                    end else begin
                        state_d = ST_FALL_TEST;
                        fcnt_d  = FW'(1);
                    end
                end
                ST_FALL_TEST: begin
                    if (s) begin
                        state_d = ST_HIGH;
                        fcnt_d  = '0;
                    end else if (fcnt_inc == FILT_MAX) begin
                        state_d = ST_LOW;
                        fall_d  = 1'b1;
                        level_d = 1'b0;
                        fcnt_d  = '0;
                    end else begin
                        fcnt_d = fcnt_inc;
                    end
                end
                ST_LOW: begin
                    if (s) begin
                        if (FILTER_LEN == 1) begin
                            state_d = ST_HIGH;
                            rise_d  = 1'b1;
                            level_d = 1'b1;
                            fcnt_d  = '0;
                        end else begin
                            state_d = ST_RISE_TEST;
                            fcnt_d  = FW'(1);
                        end
                    end
                end
                ST_RISE_TEST: begin
                    if (!s) begin
                        state_d = ST_LOW;
                        fcnt_d  = '0;
                    end else if (fcnt_inc == FILT_MAX) begin
                        state_d = ST_HIGH;
                        rise_d  = 1'b1;
                        level_d = 1'b1;
                        fcnt_d  = '0;
                    end else begin
                        fcnt_d = fcnt_inc;
                    end
                end
                default: begin
                    state_d = ST_HIGH;
                    fcnt_d  = '0;
                end
            endcase
        end

        assign FallKB[ch]  = fall_q;
        assign RiseKB[ch]  = rise_q;
        assign LevelKB[ch] = level_q;
        assign Idle[ch]    = idle_q;
    end

endmodule

// File: tb/tb_ps2_clk_edge_filter.sv
// Bench for ps2_clk_edge_filter: directed scenarios plus a random PS/2-like
// waveform, all checked against a run-length reference model of the filter.
module tb_ps2_clk_edge_filter;

    localparam int NCH = 4;
    localparam int FL  = 2;
    localparam int IC  = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] en;
    logic [NCH-1:0] clk_kb;
    logic [NCH-1:0] fall_kb, rise_kb, level_kb, idle_kb;

    ps2_clk_edge_filter #(.NUM_CH(NCH), .FILTER_LEN(FL), .IDLE_CYCLES(IC)) u_dut (
        .Clk    (clk),
        .Reset  (rst_n),
        .Enable (en),
        .ClkKB  (clk_kb),
        .FallKB (fall_kb),
        .RiseKB (rise_kb),
        .LevelKB(level_kb),
        .Idle   (idle_kb)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    // Reference: delayed samples, confirmed level, run of opposite samples, idle run.
    bit             m_p1[NCH], m_p2[NCH], m_lvl[NCH];
    int             m_opp[NCH], m_idle[NCH];
    logic [NCH-1:0] m_fall, m_rise, m_level, m_idl;
    int             m_edges = 0, d_edges = 0;
    bit             last_fall[NCH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset_ch(input int c);
        m_p1[c] = 1; m_p2[c] = 1; m_lvl[c] = 1;
        m_opp[c] = 0; m_idle[c] = 0;
        m_fall[c] = 0; m_rise[c] = 0; m_level[c] = 1; m_idl[c] = 0;
        last_fall[c] = 0;
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) model_reset_ch(c);
    endtask

    task automatic model_step();
        bit s;
        for (int c = 0; c < NCH; c++) begin
            if (!en[c]) begin
                model_reset_ch(c);
                continue;
            end
            s = m_p2[c];
            m_p2[c] = m_p1[c];
            m_p1[c] = clk_kb[c];
            m_fall[c] = 0;
            m_rise[c] = 0;
            if (s == m_lvl[c]) begin
                if (m_lvl[c]) m_idle[c] = (m_opp[c] == 0) ? ((m_idle[c] < IC) ? m_idle[c] + 1 : IC) : 0;
                m_opp[c] = 0;
            end else begin
                m_opp[c]++;
                m_idle[c] = 0;
                if (m_opp[c] == FL) begin
                    m_lvl[c] = s;
                    m_opp[c] = 0;
                    if (s) m_rise[c] = 1; else m_fall[c] = 1;
                    m_edges++;
                end
            end
            m_level[c] = m_lvl[c];
            m_idl[c]   = (m_idle[c] == IC);
        end
    endtask

    // One clock: model advances on the posedge, DUT is compared at the negedge.
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("fall",  32'(fall_kb),  32'(m_fall));
        chk("rise",  32'(rise_kb),  32'(m_rise));
        chk("level", 32'(level_kb), 32'(m_level));
        chk("idle",  32'(idle_kb),  32'(m_idl));
        if ((fall_kb & rise_kb) != 0) chk("excl", 32'(fall_kb & rise_kb), 32'd0);
        for (int c = 0; c < NCH; c++) begin
            if (fall_kb[c]) begin
                chk("alt_fall", 32'(last_fall[c]), 32'd0);
                last_fall[c] = 1;
                d_edges++;
            end
            if (rise_kb[c]) begin
                chk("alt_rise", 32'(last_fall[c]), 32'd1);
                last_fall[c] = 0;
                d_edges++;
            end
        end
    endtask

    int rem[NCH];

    initial begin
        rst_n  = 1'b0;
        en     = '1;
        clk_kb = '1;
        model_reset();
        #12;
        chk("rst_fall",  32'(fall_kb),  32'd0);
        chk("rst_rise",  32'(rise_kb),  32'd0);
        chk("rst_level", 32'(level_kb), 32'hF);
        chk("rst_idle",  32'(idle_kb),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle asserts on the 8th edge in STABLE_HIGH after reset.
        for (int n = 1; n <= 10; n++) begin
            step();
            chk("idle_rise", 32'(idle_kb[0]), 32'(n >= IC));
        end

        // Clean fall on ch0 and rise timing.
        clk_kb[0] = 1'b0;
        for (int n = 0; n < 6; n++) begin
            step();
            chk("clean_fall", 32'(fall_kb[0]), 32'(n == 3));
            chk("fall_level", 32'(level_kb[0]), 32'(n < 3));
        end
        clk_kb[0] = 1'b1;
        for (int n = 0; n < 6; n++) begin
            step();
            chk("clean_rise", 32'(rise_kb[0]), 32'(n == 3));
        end
        for (int n = 0; n < 12; n++) step();

        // Multi-channel: ch0/ch2 fall together, ch1 one-cycle glitch, ch3 stays high.
        clk_kb = 4'b1000;
        step();
        clk_kb[1] = 1'b1;
        for (int n = 1; n < 6; n++) begin
            step();
            if (n == 3) chk("multi_fall", 32'(fall_kb), 32'h5);
            chk("ch3_idle", 32'(idle_kb[3]), 32'd1);
            chk("ch1_level", 32'(level_kb[1]), 32'd1);
        end
        clk_kb = '1;
        for (int n = 0; n < 14; n++) step();

        // Disable ch0 while in FALL_TEST: no pulse, level held high.
        clk_kb[0] = 1'b0;
        for (int n = 0; n < 3; n++) step();
        en[0] = 1'b0;
        for (int n = 0; n < 4; n++) begin
            step();
            chk("dis_nofall", 32'(fall_kb[0]), 32'd0);
            chk("dis_level",  32'(level_kb[0]), 32'd1);
        end
        en[0] = 1'b1;
        for (int n = 0; n < 4; n++) step();
        clk_kb[0] = 1'b1;
        for (int n = 0; n < 8; n++) step();

        // Async reset during the FallKB cycle.
        clk_kb[2] = 1'b0;
        for (int n = 0; n < 4; n++) step();
        chk("pre_rst_fall", 32'(fall_kb[2]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_fall",  32'(fall_kb),  32'd0);
        chk("arst_level", 32'(level_kb), 32'hF);
        chk("arst_idle",  32'(idle_kb),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clk_kb = '1;

        // Random PS/2-like waveform with short glitches and rare enable drops.
        for (int c = 0; c < NCH; c++) rem[c] = 20;
        for (int cyc = 0; cyc < 8000; cyc++) begin
            for (int c = 0; c < NCH; c++) begin
                if (rem[c] == 0) begin
                    clk_kb[c] = ~clk_kb[c];
                    rem[c] = ($urandom_range(0, 3) == 0) ? 1 : int'($urandom_range(3, 40));
                end
                rem[c]--;
                if (!en[c]) en[c] = ($urandom_range(0, 3) != 0);
                else if ($urandom_range(0, 799) == 0) en[c] = 1'b0;
            end
            step();
        end
        chk("edge_count", 32'(d_edges), 32'(m_edges));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
